neuro_brain_ctrl: RTL and testbench
===================================

# neuro_brain_ctrl

Configuration and run sequencer for the neuron array. It accepts a configuration bitstream as bytes over a valid/ready handshake and serializes it MSB-first into the neuron shift chain while driving `conf_en`. It then clears all membrane voltages, gates the array into run mode, and generates the 8-line decay clock bus `dbus` shared by every neuron. It sits between the chip pins and the array's `conf_en`/`bs_in`/`nn_reset`/`dBus` inputs.

## Interface
Parameters:
- `CHAIN_LEN`, 425: total chain bits, 25 neurons × 17 bits (wA, wB, wC, tSel: 3 each; U: 5).
- `RESET_CYCLES`, 4: cycles of `neuron_reset` held after a load before `loaded` rises.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `nn_reset`  in  1  asynchronous, active-high reset.
- `byte_in`  in  8  configuration byte; bit 7 is shifted first.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  byte is accepted on an edge where `byte_valid & byte_ready`.
- `run_en`  in  1  request run mode after a successful load.
- `chain_in`  in  1  tail of the neuron chain (last neuron's `bs_out`).
- `conf_en`  out  1  chain shift enable.
- `bs_out`  out  1  serial bit into the head of the chain.
- `neuron_reset`  out  1  drives the array's `nn_reset`; high means U<=1.
- `dbus`  out  8  decay clock bus.
- `busy`  out  1  high in LOAD and CLEAR.
- `loaded`  out  1  the array holds a complete configuration.
- `err`  out  1  sticky underrun flag.
- `readback`  out  8  last 8 chain-tail bits (macro-dependent).

## Operation
- All outputs are registered. Reset values: state IDLE, `conf_en`=0, `bs_out`=0, `neuron_reset`=1, `dbus`=0, `byte_ready`=0, `busy`=0, `loaded`=0, `err`=0, `readback`=0. `byte_ready` rises on the first edge after reset is released.
- Datapath: an 8-bit shifter, a 1-byte holding register, a 9-bit bit counter, and an 8-bit decay counter.
- IDLE: `byte_ready`=1 and `neuron_reset`=1. An accepted byte clears `err` and `loaded`, clears the bit counter, loads the shifter, and moves to LOAD.
- LOAD: `conf_en`=1 and `busy`=1, with one bit shifted per cycle. `byte_ready` equals "holding register empty". When the shifter drains, it reloads from the holding register with no bubble.
  - Underrun: the shifter is empty, the holding register is empty, and the bit count is below `CHAIN_LEN`. Response: `err`=1, `conf_en`=0 on the next edge, then IDLE.
  - Stalls are not permitted, because U stages corrupt while `conf_en` is low.
- After bit `CHAIN_LEN`-1 is shifted, go to CLEAR. Bits left in the final byte are discarded (425 mod 8 = 1: only bit 7 of byte 54 is used).
  - `byte_ready`=0 once 54 bytes have been taken.
- CLEAR: `conf_en`=0 and `neuron_reset`=1 for `RESET_CYCLES` cycles, then READY.
- READY: `loaded`=1, `neuron_reset`=1, `dbus`=0. If `run_en`=1, go to RUN.
- RUN: `neuron_reset`=0. The decay counter starts at 0 and increments every cycle, wrapping at 255.
  - `dbus[k]` is high for the single cycle in which `counter[k:0]` is all ones, giving period 2^(k+1).
  - If `run_en`=0, go to READY: counter cleared, `dbus`=0.
- In READY or RUN, `byte_ready`=1. An accepted byte aborts the run and starts a new LOAD. `neuron_reset` goes high in the same cycle that `conf_en` goes high.
- `nn_reset` asserted in any state forces reset values immediately; any partial load is lost.

## Timing
- A byte accepted at edge k puts bit 7 on `bs_out` with `conf_en`=1 during cycle k→k+1. Bit i appears in cycle k+i→k+i+1.
- For back-to-back bytes, `conf_en` stays high for exactly `CHAIN_LEN` consecutive cycles.
- Sender deadline: the next byte must be accepted no later than the edge at which the current shifter's bit 0 is consumed.
- Timeline after a load: `neuron_reset` high for `RESET_CYCLES` cycles, then `loaded`=1 on the next edge.
- Entering RUN: if `run_en` is sampled high at edge r, then `neuron_reset`=0 from r. `dbus[0]` first pulses in cycle r+1; `dbus[7]` first pulses in cycle r+255.
- Simultaneous `run_en` and a byte accept in READY: the byte wins, and the block goes to LOAD.

## Configuration
- `NEUROCHIP_READBACK_EN` defined: during every `conf_en` cycle, `readback <= {readback[6:0], chain_in}`. `readback` is cleared at the start of each LOAD and holds its value outside LOAD. This gives host-visible verification of the previous chain contents.
- Not defined: `readback` is tied to 8'h00 and `chain_in` is unused.

## Test plan
- Reset: assert `nn_reset` at bit 100 of a load → all outputs return to reset values within the same cycle. After release, `byte_ready`=1 and `loaded`=0.
- Full load: 54 back-to-back bytes 8'hA5 → `conf_en` high exactly 425 cycles and `bs_out` follows 1,0,1,0,0,1,0,1,… Then `neuron_reset`=1 for 4 cycles, `loaded`=1, `err`=0.
- Underrun: drop `byte_valid` after byte 3 → `err`=1 after bit 24 is shifted, `conf_en`=0, state IDLE, `loaded`=0. A following full load clears `err`.
- Run: load, then `run_en`=1 → `neuron_reset`=0. `dbus[0]` pulses every 2 cycles, `dbus[3]` every 16, and `dbus[7]` once per 256. With `run_en`=0, `dbus`=0 and `neuron_reset`=1 on the next edge.
- Reload in RUN: offer a byte while running → accepted, `neuron_reset`=1, `conf_en`=1, `loaded`=0. Completion returns to READY.
- With `NEUROCHIP_READBACK_EN`: drive `chain_in` with the pattern 1,1,0,0,1,0,1,1 over the last 8 conf cycles → `readback`=8'hCB after the load. Without the macro, `readback`=8'h00.

Source files
------------

// File: rtl/neuro_brain_ctrl.sv
// neuro_brain_ctrl: byte-fed configuration loader, membrane clear and decay-bus sequencer for the neuron array.
// Optional readback of the chain tail is compiled in with NEUROCHIP_READBACK_EN.
module neuro_brain_ctrl #(
    parameter int CHAIN_LEN    = 425,
    parameter int RESET_CYCLES = 4
) (
    input  logic       clk,
    input  logic       nn_reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       run_en,
    input  logic       chain_in,
    output logic       conf_en,
    output logic       bs_out,
    output logic       neuron_reset,
    output logic [7:0] dbus,
    output logic       busy,
    output logic       loaded,
    output logic       err,
    output logic [7:0] readback
);
    localparam logic [8:0] LAST_BIT = 9'(CHAIN_LEN);
    localparam logic [8:0] N_BYTES  = 9'((CHAIN_LEN + 7) / 8);
    localparam logic [7:0] CLR_LAST = 8'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, READY, RUN} state_t;

    state_t     state_q, state_d;
    logic [7:0] sh_q, sh_d, hold_q, hold_d, dcnt_q, dcnt_d, clr_cnt_q, clr_cnt_d, dbus_q, pulse, src;
    logic [3:0] rem_q, rem_d;
    logic [8:0] bit_cnt_q, bit_cnt_d, byte_cnt_q, byte_cnt_d;
    logic       hold_full_q, hold_full_d, err_q, err_d, bs_out_q, bs_out_d;
    logic       conf_en_q, conf_en_d, neuron_reset_q, neuron_reset_d, byte_ready_q, byte_ready_d;
    logic       busy_q, busy_d, loaded_q, loaded_d, acc, start;

    assign acc   = byte_valid & byte_ready_q;
    assign start = acc && (state_q inside {IDLE, READY, RUN});
    assign src   = hold_full_q ? hold_q : byte_in;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        rem_d       = rem_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        clr_cnt_d   = clr_cnt_q;
        err_d       = err_q;
        bs_out_d    = bs_out_q;
        unique case (state_q)
            LOAD: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = CLEAR;
                    clr_cnt_d = 8'd0;
                end else if (rem_q != 4'd0) begin
                    {bs_out_d, sh_d} = {sh_q, 1'b0};
                    rem_d            = rem_q - 4'd1;
                    bit_cnt_d        = bit_cnt_q + 9'd1;
                    if (acc) begin
                        hold_d      = byte_in;
                        hold_full_d = 1'b1;
                        byte_cnt_d  = byte_cnt_q + 9'd1;
                    end
                end else if (hold_full_q | acc) begin
                    // shifter drained: refill without a bubble, straight from byte_in if it arrives now
                    {bs_out_d, sh_d} = {src, 1'b0};
                    rem_d            = 4'd7;
                    bit_cnt_d        = bit_cnt_q + 9'd1;
                    hold_full_d      = 1'b0;
                    byte_cnt_d       = byte_cnt_q + {8'd0, acc};
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            CLEAR:   if (clr_cnt_q == CLR_LAST) state_d = READY; else clr_cnt_d = clr_cnt_q + 8'd1;
            READY:   if (run_en) state_d = RUN;
            RUN:     if (!run_en) state_d = READY;
            default: ;
        endcase
        if (start) begin
            state_d          = LOAD;
            {bs_out_d, sh_d} = {byte_in, 1'b0};
            rem_d            = 4'd7;
            bit_cnt_d        = 9'd1;
            byte_cnt_d       = 9'd1;
            hold_full_d      = 1'b0;
            err_d            = 1'b0;
        end
        dcnt_d         = (state_q == RUN && state_d == RUN) ? dcnt_q + 8'd1 : 8'd0;
        conf_en_d      = state_d == LOAD;
        busy_d         = state_d inside {LOAD, CLEAR};
        loaded_d       = state_d inside {READY, RUN};
        neuron_reset_d = state_d != RUN;
        byte_ready_d   = (state_d inside {IDLE, READY, RUN}) ||
                         (state_d == LOAD && !hold_full_d && byte_cnt_d < N_BYTES);
    end

    for (genvar k = 0; k < 8; k++) begin : g_pulse
        assign pulse[k] = &dcnt_d[k:0];
    end

    always_ff @(posedge clk or posedge nn_reset) begin
        if (nn_reset) begin
            state_q        <= IDLE;
            sh_q           <= 8'd0;
            rem_q          <= 4'd0;
            hold_q         <= 8'd0;
            hold_full_q    <= 1'b0;
            bit_cnt_q      <= 9'd0;
            byte_cnt_q     <= 9'd0;
            clr_cnt_q      <= 8'd0;
            dcnt_q         <= 8'd0;
            err_q          <= 1'b0;
            bs_out_q       <= 1'b0;
            conf_en_q      <= 1'b0;
            neuron_reset_q <= 1'b1;
            dbus_q         <= 8'd0;
            byte_ready_q   <= 1'b0;
            busy_q         <= 1'b0;
            loaded_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            sh_q           <= sh_d;
            rem_q          <= rem_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            bit_cnt_q      <= bit_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            clr_cnt_q      <= clr_cnt_d;
            dcnt_q         <= dcnt_d;
            err_q          <= err_d;
            bs_out_q       <= bs_out_d;
            conf_en_q      <= conf_en_d;
            neuron_reset_q <= neuron_reset_d;
            dbus_q         <= (state_d == RUN) ? pulse : 8'd0;
            byte_ready_q   <= byte_ready_d;
            busy_q         <= busy_d;
            loaded_q       <= loaded_d;
        end
    end

`ifdef NEUROCHIP_READBACK_EN
    logic [7:0] readback_q;
    always_ff @(posedge clk or posedge nn_reset) begin
        if (nn_reset) readback_q <= 8'd0;
        else if (start) readback_q <= 8'd0;
        else if (conf_en_q) readback_q <= {readback_q[6:0], chain_in};
    end
    assign readback = readback_q;
`else
    logic unused_chain_in;
    assign unused_chain_in = chain_in;
    assign readback        = 8'h00;
`endif

    assign byte_ready   = byte_ready_q;
    assign conf_en      = conf_en_q;
    assign bs_out       = bs_out_q;
    assign neuron_reset = neuron_reset_q;
    assign dbus         = dbus_q;
    assign busy         = busy_q;
    assign loaded       = loaded_q;
    assign err          = err_q;
endmodule

// File: tb/tb_neuro_brain_ctrl.sv
// tb_neuro_brain_ctrl: directed and randomized checks of neuro_brain_ctrl against a bit-stream and decay-period model.
module tb_neuro_brain_ctrl;
    localparam int CHAIN = 425;
    localparam int RCYC  = 4;

    logic       clk = 1'b0, nn_reset = 1'b1, byte_valid = 1'b0, run_en = 1'b0, chain_in = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_ready, conf_en, bs_out, neuron_reset, busy, loaded, err;
    logic [7:0] dbus, readback;

    int         errors = 0, checks = 0;
    logic [7:0] bytes_q[$];
    logic [7:0] rb_model = 8'd0;
    int         n_conf, n_taken, nb;
    bit         load_done;

    neuro_brain_ctrl #(.CHAIN_LEN(CHAIN), .RESET_CYCLES(RCYC)) dut (
        .clk(clk), .nn_reset(nn_reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .run_en(run_en), .chain_in(chain_in), .conf_en(conf_en),
        .bs_out(bs_out), .neuron_reset(neuron_reset), .dbus(dbus), .busy(busy),
        .loaded(loaded), .err(err), .readback(readback)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rb();
`ifdef NEUROCHIP_READBACK_EN
        return rb_model;
`else
        return 8'h00;
`endif
    endfunction

    // dbus[k] fires once every 2^(k+1) cycles, on the last cycle of each period
    function automatic logic [7:0] exp_dbus(input int j);
        logic [7:0] r = 8'd0;
        for (int k = 0; k < 8; k++) r[k] = (j % (2 << k)) == (2 << k) - 1;
        return r;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_conf_en"}, conf_en, 0);
        check({tag, "_bs_out"}, bs_out, 0);
        check({tag, "_neuron_reset"}, neuron_reset, 1);
        check({tag, "_dbus"}, dbus, 0);
        check({tag, "_byte_ready"}, byte_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_loaded"}, loaded, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_readback"}, readback, 0);
    endtask

    // Offer nb bytes as fast as the block takes them; the expected chain stream is the bytes MSB-first.
    task automatic load(input int nbytes, input bit a5, input int rst_bit);
        int         idx = 0, bitpos = 0;
        bit         acc, started = 0;
        logic [7:0] b;
        logic [7:0] pat = 8'hCB;
        bytes_q.delete();
        for (int i = 0; i < nbytes; i++) bytes_q.push_back(a5 ? 8'hA5 : 8'($urandom));
        rb_model  = 8'd0;
        load_done = 0;
        for (int cyc = 0; cyc < 1000 && !load_done; cyc++) begin
            byte_valid = idx < nbytes;
            byte_in    = byte_valid ? bytes_q[idx] : 8'($urandom);
            acc        = byte_valid & byte_ready;
            tick();
            run_en = 1'b0;
            if (acc) idx++;
            if (conf_en) begin
                if (bitpos == 0) begin
                    check("start_neuron_reset", neuron_reset, 1);
                    check("start_loaded", loaded, 0);
                    check("start_busy", busy, 1);
                    check("start_err", err, 0);
                    check("start_dbus", dbus, 0);
                end
                started = 1;
                b = bytes_q[bitpos / 8];
                check("bs_out", bs_out, b[7 - bitpos % 8]);
                if (bitpos == CHAIN - 1) check("ready_after_last_byte", byte_ready, 0);
                chain_in = (bitpos >= CHAIN - 8) ? pat[7 - (bitpos - (CHAIN - 8))] : 1'($urandom);
                rb_model = {rb_model[6:0], chain_in};
                bitpos++;
                if (bitpos - 1 == rst_bit) begin
                    #2;
                    nn_reset = 1'b1;
                    #1;
                    check_reset_vals("mid_reset");
                    @(posedge clk);
                    #1;
                    nn_reset  = 1'b0;
                    load_done = 1;
                end
            end else if (started) load_done = 1;
        end
        byte_valid = 1'b0;
        n_conf     = bitpos;
        n_taken    = idx;
        check("load_done", load_done, 1);
    endtask

    task automatic clear_wait();
        int clr = 0, bad = 0;
        while (loaded !== 1'b1 && clr < 20) begin
            if (neuron_reset !== 1'b1 || conf_en !== 1'b0 || busy !== 1'b1) bad++;
            tick();
            clr++;
        end
        check("clear_cycles", clr, RCYC);
        check("clear_signals", bad, 0);
        check("ready_loaded", loaded, 1);
        check("ready_err", err, 0);
        check("ready_busy", busy, 0);
        check("ready_byte_ready", byte_ready, 1);
        check("ready_neuron_reset", neuron_reset, 1);
        check("ready_dbus", dbus, 0);
        check("ready_conf_en", conf_en, 0);
    endtask

    initial begin
        bit mrun = 0;
        int j = 0, p0 = 0, p3 = 0, p7 = 0, first7 = -1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        nn_reset = 1'b0;
        tick();
        check("idle_byte_ready", byte_ready, 1);
        check("idle_loaded", loaded, 0);
        check("idle_neuron_reset", neuron_reset, 1);
        check("idle_busy", busy, 0);

        load(54, 1, -1);
        check("a5_conf_cycles", n_conf, CHAIN);
        check("a5_bytes_taken", n_taken, 54);
        clear_wait();
        check("a5_readback", readback, exp_rb());
`ifdef NEUROCHIP_READBACK_EN
        check("a5_readback_pattern", readback, 8'hCB);
`endif

        for (int c = 0; c < 900; c++) begin
            run_en   = (c < 600) ? 1'b1 : 1'(($urandom % 4) != 0);
            chain_in = 1'($urandom);
            tick();
            if (!mrun && run_en) begin
                mrun = 1;
                j    = 0;
            end else if (mrun && run_en) j++;
            else mrun = 0;
            check("run_dbus", dbus, mrun ? exp_dbus(j) : 8'd0);
            check("run_neuron_reset", neuron_reset, !mrun);
            if (c < 600) begin
                p0 += int'(dbus[0]);
                p3 += int'(dbus[3]);
                p7 += int'(dbus[7]);
                if (dbus[7] && first7 < 0) first7 = c;
            end
        end
        check("dbus0_pulses", p0, 300);
        check("dbus3_pulses", p3, 37);
        check("dbus7_pulses", p7, 2);
        check("dbus7_first", first7, 255);
        check("run_loaded", loaded, 1);
        check("run_readback_hold", readback, exp_rb());

        run_en = 1'b1;
        tick();
        check("in_run", neuron_reset, 0);
        load(54, 0, -1);
        check("reload_conf_cycles", n_conf, CHAIN);
        clear_wait();
        check("reload_readback", readback, exp_rb());

        run_en = 1'b1;
        load(3, 0, -1);
        check("underrun_conf_cycles", n_conf, 24);
        check("underrun_err", err, 1);
        check("underrun_loaded", loaded, 0);
        check("underrun_busy", busy, 0);
        check("underrun_byte_ready", byte_ready, 1);
        check("underrun_neuron_reset", neuron_reset, 1);
        check("underrun_readback", readback, exp_rb());
        repeat (5) tick();
        check("err_sticky", err, 1);
        check("idle_conf_en", conf_en, 0);

        nb = 1 + int'($urandom % 6);
        load(nb, 0, -1);
        check("rand_underrun_conf_cycles", n_conf, 8 * nb);
        check("rand_underrun_err", err, 1);

        load(54, 0, -1);
        check("recover_conf_cycles", n_conf, CHAIN);
        clear_wait();

        load(54, 0, 100);
        tick();
        check("post_reset_byte_ready", byte_ready, 1);
        check("post_reset_loaded", loaded, 0);
        check("post_reset_conf_en", conf_en, 0);
        check("post_reset_err", err, 0);

        load(54, 0, -1);
        check("final_conf_cycles", n_conf, CHAIN);
        clear_wait();
        check("final_readback", readback, exp_rb());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
